// File: rtl/riscv_pkg.sv
// Shared RV32I decode definitions: ALU operation codes, opcodes and funct7 encodings.
package riscv_pkg;

   typedef enum logic [3:0] {
      ADD  = 4'd0,
      SUB  = 4'd1,
      SLL  = 4'd2,
      SLT  = 4'd3,
      SLTU = 4'd4,
      XOR  = 4'd5,
      SRL  = 4'd6,
      SRA  = 4'd7,
      OR   = 4'd8,
      AND  = 4'd9,
      SUBI = 4'd10
   } alu_op_t;

   localparam logic [6:0] OPC_OP     = 7'b0110011;
   localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
   localparam logic [6:0] F7_BASE    = 7'b0000000;
   localparam logic [6:0] F7_ALT     = 7'b0100000;

   // funct3 -> operation for the base (funct7 = 0) encodings of OP / OP-IMM.
   function automatic alu_op_t funct3_to_op(input logic [2:0] f3);
      case (f3)
         3'b000:  return ADD;
         3'b001:  return SLL;
         3'b010:  return SLT;
         3'b011:  return SLTU;
         3'b100:  return XOR;
         3'b101:  return SRL;
         3'b110:  return OR;
         default: return AND;
      endcase
   endfunction

endpackage

// File: rtl/decode_stage_reg_file.sv
// 32x32 register file: two combinational reads with same-cycle write bypass, x0 hardwired to zero.
module reg_file
   import riscv_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic [4:0]  raddr1_i,
   input  logic [4:0]  raddr2_i,
   output logic [31:0] rdata1_o,
   output logic [31:0] rdata2_o,
   input  logic        we_i,
   input  logic [4:0]  waddr_i,
   input  logic [31:0] wdata_i
);

   logic [31:0] regs_q [32];

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < 32; i++) regs_q[i] <= '0;
      end else if (we_i && waddr_i != 5'd0) begin
         regs_q[waddr_i] <= wdata_i;
      end
   end

   always_comb begin
      rdata1_o = regs_q[raddr1_i];
      rdata2_o = regs_q[raddr2_i];
      if (we_i && waddr_i == raddr1_i) rdata1_o = wdata_i;
      if (we_i && waddr_i == raddr2_i) rdata2_o = wdata_i;
      if (raddr1_i == 5'd0) rdata1_o = '0;
      if (raddr2_i == 5'd0) rdata2_o = '0;
   end

endmodule

// File: rtl/decode_stage.sv
// RV32I OP/OP-IMM decode with busy-bit scoreboard and a single registered valid/ready output slot.
module decode_stage
   import riscv_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [31:0] in_instr,
   output logic        out_valid,
   input  logic        out_ready,
   output alu_op_t     operation,
   output logic [31:0] op1,
   output logic [31:0] op2,
   output logic [4:0]  rd,
   output logic        illegal,
   input  logic        wb_en,
   input  logic [4:0]  wb_rd,
   input  logic [31:0] wb_data
);

   logic [6:0]  opcode, funct7;
   logic [2:0]  funct3;
   logic [4:0]  rs1, rs2, rd_f;
   logic [31:0] rs1_data, rs2_data, op2_val;
   logic        legal, uses_rs2, shift;
   alu_op_t     alu_op;
   logic        rs1_busy, rs2_busy, stall, accept;
   logic [31:0] busy_q, busy_d;

   logic        out_valid_q, illegal_q;
   alu_op_t     op_q;
   logic [31:0] op1_q, op2_q;
   logic [4:0]  rd_q;

   assign opcode = in_instr[6:0];
   assign rd_f   = in_instr[11:7];
   assign funct3 = in_instr[14:12];
   assign rs1    = in_instr[19:15];
   assign rs2    = in_instr[24:20];
   assign funct7 = in_instr[31:25];

   reg_file u_rf (
      .clk      (clk),
      .rst      (rst),
      .raddr1_i (rs1),
      .raddr2_i (rs2),
      .rdata1_o (rs1_data),
      .rdata2_o (rs2_data),
      .we_i     (wb_en),
      .waddr_i  (wb_rd),
      .wdata_i  (wb_data)
   );

   always_comb begin
      legal    = 1'b0;
      alu_op   = ADD;
      uses_rs2 = 1'b0;
      case (opcode)
         OPC_OP: begin
            uses_rs2 = 1'b1;
            if (funct7 == F7_BASE) begin
               legal  = 1'b1;
               alu_op = funct3_to_op(funct3);
            end else if (funct7 == F7_ALT && funct3 == 3'b000) begin
               legal  = 1'b1;
               alu_op = SUB;
            end else if (funct7 == F7_ALT && funct3 == 3'b101) begin
               legal  = 1'b1;
               alu_op = SRA;
            end
         end
         OPC_OP_IMM: begin
            case (funct3)
               3'b001: begin
                  if (funct7 == F7_BASE) begin
                     legal  = 1'b1;
                     alu_op = SLL;
                  end
               end
               3'b101: begin
                  if (funct7 == F7_BASE) begin
                     legal  = 1'b1;
                     alu_op = SRL;
                  end else if (funct7 == F7_ALT) begin
                     legal  = 1'b1;
                     alu_op = SRA;
                  end
               end
               default: begin
                  legal  = 1'b1;
                  alu_op = funct3_to_op(funct3);
               end
            endcase
         end
         default: ;
      endcase
      shift = (alu_op == SLL) || (alu_op == SRL) || (alu_op == SRA);
   end

   // For OP-IMM shifts the low five bits of the immediate are exactly shamt.
   always_comb begin
      if (opcode == OPC_OP) op2_val = rs2_data;
      else                  op2_val = {{20{in_instr[31]}}, in_instr[31:20]};
      if (shift) op2_val = {27'd0, op2_val[4:0]};
   end

   // A writeback landing this cycle releases the hazard immediately via the bypass.
   assign rs1_busy = busy_q[rs1] && !(wb_en && wb_rd == rs1);
   assign rs2_busy = busy_q[rs2] && !(wb_en && wb_rd == rs2);
   assign stall    = legal && (rs1_busy || (uses_rs2 && rs2_busy));
   assign in_ready = !stall && (!out_valid_q || out_ready);
   assign accept   = in_valid && in_ready;

   always_comb begin
      busy_d = busy_q;
      if (wb_en && wb_rd != 5'd0)              busy_d[wb_rd] = 1'b0;
      if (accept && legal && rd_f != 5'd0)     busy_d[rd_f]  = 1'b1;
      busy_d[0] = 1'b0;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         busy_q      <= '0;
         out_valid_q <= 1'b0;
         op_q        <= ADD;
         op1_q       <= '0;
         op2_q       <= '0;
         rd_q        <= '0;
         illegal_q   <= 1'b0;
      end else begin
         busy_q <= busy_d;
         if (accept) begin
            out_valid_q <= 1'b1;
            op_q        <= legal ? alu_op   : ADD;
            op1_q       <= legal ? rs1_data : 32'd0;
            op2_q       <= legal ? op2_val  : 32'd0;
            rd_q        <= legal ? rd_f     : 5'd0;
            illegal_q   <= !legal;
         end else if (out_ready) begin
            out_valid_q <= 1'b0;
         end
      end
   end

   assign out_valid = out_valid_q;
   assign operation = op_q;
   assign op1       = op1_q;
   assign op2       = op2_q;
   assign rd        = rd_q;
   assign illegal   = illegal_q;

endmodule

// File: tb/tb_decode_stage.sv
// Directed self-checking bench for decode_stage: decode, hazards, bypass, backpressure and reset.
module tb_decode_stage;
   import riscv_pkg::*;

   logic        clk = 1'b0;
   logic        rst, in_valid, in_ready, out_valid, out_ready, illegal, wb_en;
   logic [31:0] in_instr, op1, op2, wb_data;
   logic [4:0]  rd, wb_rd;
   alu_op_t     operation;
   int          checks = 0;
   int          errors = 0;

   always #5 clk = ~clk;

   decode_stage dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_instr  (in_instr),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .operation (operation),
      .op1       (op1),
      .op2       (op2),
      .rd        (rd),
      .illegal   (illegal),
      .wb_en     (wb_en),
      .wb_rd     (wb_rd),
      .wb_data   (wb_data)
   );

   function automatic logic [31:0] r_type(input logic [6:0] f7, input logic [4:0] r2, input logic [4:0] r1,
                                          input logic [2:0] f3, input logic [4:0] rdi, input logic [6:0] opc);
      return {f7, r2, r1, f3, rdi, opc};
   endfunction

   function automatic logic [31:0] i_type(input logic [11:0] imm, input logic [4:0] r1, input logic [2:0] f3,
                                          input logic [4:0] rdi, input logic [6:0] opc);
      return {imm, r1, f3, rdi, opc};
   endfunction

   task automatic drive(input logic v, input logic [31:0] ins, input logic we, input logic [4:0] wr,
                        input logic [31:0] wd);
      @(negedge clk);
      in_valid = v; in_instr = ins; wb_en = we; wb_rd = wr; wb_data = wd;
      #1;
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset;
      rst = 1'b1; out_ready = 1'b1;
      drive(1'b1, r_type(F7_BASE, 5'd2, 5'd1, 3'b000, 5'd3, OPC_OP), 1'b0, 5'd0, 32'd0);
      tick; tick;
      checks++; if (out_valid !== 1'b0)  begin errors++; $display("FAIL rst_out_valid: got %b want 0", out_valid); end
      checks++; if (operation !== ADD)   begin errors++; $display("FAIL rst_operation: got %0d want 0", operation); end
      checks++; if (op1 !== 32'd0)       begin errors++; $display("FAIL rst_op1: got %h want 0", op1); end
      checks++; if (op2 !== 32'd0)       begin errors++; $display("FAIL rst_op2: got %h want 0", op2); end
      checks++; if (rd !== 5'd0)         begin errors++; $display("FAIL rst_rd: got %0d want 0", rd); end
      checks++; if (illegal !== 1'b0)    begin errors++; $display("FAIL rst_illegal: got %b want 0", illegal); end
      @(negedge clk); rst = 1'b0; in_valid = 1'b0; #1;
      checks++; if (in_ready !== 1'b1)   begin errors++; $display("FAIL rst_in_ready: got %b want 1", in_ready); end
   endtask

   task automatic test_addi_add;
      drive(1'b0, 32'd0, 1'b1, 5'd1, 32'd5); tick;
      drive(1'b1, i_type(12'hFFD, 5'd1, 3'b000, 5'd2, OPC_OP_IMM), 1'b0, 5'd0, 32'd0);
      checks++; if (in_ready !== 1'b1)      begin errors++; $display("FAIL addi_ready: got %b want 1", in_ready); end
      tick;
      checks++; if (out_valid !== 1'b1)     begin errors++; $display("FAIL addi_valid: got %b want 1", out_valid); end
      checks++; if (operation !== ADD)      begin errors++; $display("FAIL addi_op: got %0d want 0", operation); end
      checks++; if (op1 !== 32'd5)          begin errors++; $display("FAIL addi_op1: got %h want 5", op1); end
      checks++; if (op2 !== 32'hFFFFFFFD)   begin errors++; $display("FAIL addi_op2: got %h want fffffffd", op2); end
      checks++; if (rd !== 5'd2)            begin errors++; $display("FAIL addi_rd: got %0d want 2", rd); end
      drive(1'b1, r_type(F7_BASE, 5'd1, 5'd2, 3'b000, 5'd3, OPC_OP), 1'b0, 5'd0, 32'd0);
      checks++; if (in_ready !== 1'b0)      begin errors++; $display("FAIL add_stall: got %b want 0", in_ready); end
      tick;
      checks++; if (out_valid !== 1'b0)     begin errors++; $display("FAIL add_stall_valid: got %b want 0", out_valid); end
      drive(1'b1, r_type(F7_BASE, 5'd1, 5'd2, 3'b000, 5'd3, OPC_OP), 1'b1, 5'd2, 32'd2);
      checks++; if (in_ready !== 1'b1)      begin errors++; $display("FAIL add_wb_release: got %b want 1", in_ready); end
      tick;
      checks++; if (op1 !== 32'd2)          begin errors++; $display("FAIL add_bypass_op1: got %h want 2", op1); end
      checks++; if (op2 !== 32'd5)          begin errors++; $display("FAIL add_op2: got %h want 5", op2); end
      checks++; if (rd !== 5'd3)            begin errors++; $display("FAIL add_rd: got %0d want 3", rd); end
      drive(1'b0, 32'd0, 1'b1, 5'd3, 32'd7); tick;
   endtask

   task automatic test_shifts;
      drive(1'b1, i_type({F7_ALT, 5'd31}, 5'd1, 3'b101, 5'd4, OPC_OP_IMM), 1'b0, 5'd0, 32'd0); tick;
      checks++; if (operation !== SRA)      begin errors++; $display("FAIL srai_op: got %0d want 7", operation); end
      checks++; if (op2 !== 32'd31)         begin errors++; $display("FAIL srai_op2: got %h want 1f", op2); end
      checks++; if (illegal !== 1'b0)       begin errors++; $display("FAIL srai_illegal: got %b want 0", illegal); end
      drive(1'b0, 32'd0, 1'b1, 5'd4, 32'hFFFFFF25); tick;
      drive(1'b1, r_type(F7_BASE, 5'd4, 5'd1, 3'b001, 5'd5, OPC_OP), 1'b0, 5'd0, 32'd0);
      checks++; if (in_ready !== 1'b1)      begin errors++; $display("FAIL sll_ready: got %b want 1", in_ready); end
      tick;
      checks++; if (operation !== SLL)      begin errors++; $display("FAIL sll_op: got %0d want 2", operation); end
      checks++; if (op2 !== 32'd5)          begin errors++; $display("FAIL sll_op2: got %h want 5", op2); end
      drive(1'b0, 32'd0, 1'b1, 5'd5, 32'd0); tick;
   endtask

   task automatic test_illegal;
      drive(1'b1, i_type(12'h004, 5'd1, 3'b010, 5'd6, 7'b0000011), 1'b0, 5'd0, 32'd0); tick;
      checks++; if (illegal !== 1'b1)       begin errors++; $display("FAIL load_illegal: got %b want 1", illegal); end
      checks++; if (rd !== 5'd0)            begin errors++; $display("FAIL load_rd: got %0d want 0", rd); end
      checks++; if (op1 !== 32'd0)          begin errors++; $display("FAIL load_op1: got %h want 0", op1); end
      checks++; if (out_valid !== 1'b1)     begin errors++; $display("FAIL load_valid: got %b want 1", out_valid); end
      drive(1'b1, r_type(F7_BASE, 5'd6, 5'd6, 3'b000, 5'd7, OPC_OP), 1'b0, 5'd0, 32'd0);
      checks++; if (in_ready !== 1'b1)      begin errors++; $display("FAIL after_load_ready: got %b want 1", in_ready); end
      tick;
      checks++; if (illegal !== 1'b0 || rd !== 5'd7) begin errors++; $display("FAIL after_load_out: got ill=%b rd=%0d want ill=0 rd=7", illegal, rd); end
      drive(1'b1, r_type(F7_ALT, 5'd1, 5'd1, 3'b001, 5'd8, OPC_OP), 1'b0, 5'd0, 32'd0); tick;
      checks++; if (illegal !== 1'b1)       begin errors++; $display("FAIL badf7_illegal: got %b want 1", illegal); end
      checks++; if (op2 !== 32'd0)          begin errors++; $display("FAIL badf7_op2: got %h want 0", op2); end
      drive(1'b1, r_type(F7_BASE, 5'd1, 5'd8, 3'b000, 5'd9, OPC_OP), 1'b0, 5'd0, 32'd0);
      checks++; if (in_ready !== 1'b1)      begin errors++; $display("FAIL after_badf7_ready: got %b want 1", in_ready); end
      tick;
      checks++; if (rd !== 5'd9 || op2 !== 32'd5) begin errors++; $display("FAIL after_badf7_out: got rd=%0d op2=%h want rd=9 op2=5", rd, op2); end
      drive(1'b0, 32'd0, 1'b1, 5'd9, 32'd0); tick;
   endtask

   task automatic test_backpressure;
      drive(1'b0, 32'd0, 1'b0, 5'd0, 32'd0); tick;
      drive(1'b1, r_type(F7_BASE, 5'd1, 5'd1, 3'b000, 5'd10, OPC_OP), 1'b0, 5'd0, 32'd0);
      out_ready = 1'b0;
      tick;
      checks++; if (out_valid !== 1'b1 || rd !== 5'd10) begin errors++; $display("FAIL bp_first: got v=%b rd=%0d want v=1 rd=10", out_valid, rd); end
      for (int i = 0; i < 3; i++) begin
         drive(1'b1, r_type(F7_ALT, 5'd0, 5'd1, 3'b000, 5'd11, OPC_OP), 1'b0, 5'd0, 32'd0);
         checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_ready[%0d]: got %b want 0", i, in_ready); end
         tick;
         checks++; if (out_valid !== 1'b1 || rd !== 5'd10 || op1 !== 32'd5 || operation !== ADD)
            begin errors++; $display("FAIL bp_hold[%0d]: got v=%b rd=%0d op1=%h op=%0d want v=1 rd=10 op1=5 op=0", i, out_valid, rd, op1, operation); end
      end
      drive(1'b1, r_type(F7_ALT, 5'd0, 5'd1, 3'b000, 5'd11, OPC_OP), 1'b0, 5'd0, 32'd0);
      out_ready = 1'b1; #1;
      checks++; if (in_ready !== 1'b1)      begin errors++; $display("FAIL bp_release: got %b want 1", in_ready); end
      tick;
      checks++; if (out_valid !== 1'b1 || rd !== 5'd11 || operation !== SUB || op1 !== 32'd5 || op2 !== 32'd0)
         begin errors++; $display("FAIL bp_second: got v=%b rd=%0d op=%0d op1=%h op2=%h want v=1 rd=11 op=1 op1=5 op2=0", out_valid, rd, operation, op1, op2); end
      drive(1'b0, 32'd0, 1'b0, 5'd0, 32'd0); tick;
      checks++; if (out_valid !== 1'b0)     begin errors++; $display("FAIL bp_drain: got %b want 0", out_valid); end
   endtask

   task automatic test_x0_race;
      drive(1'b1, r_type(F7_BASE, 5'd1, 5'd1, 3'b000, 5'd0, OPC_OP), 1'b0, 5'd0, 32'd0); tick;
      checks++; if (rd !== 5'd0 || illegal !== 1'b0) begin errors++; $display("FAIL x0_out: got rd=%0d ill=%b want rd=0 ill=0", rd, illegal); end
      drive(1'b1, r_type(F7_BASE, 5'd0, 5'd0, 3'b000, 5'd12, OPC_OP), 1'b0, 5'd0, 32'd0);
      checks++; if (in_ready !== 1'b1)      begin errors++; $display("FAIL x0_not_busy: got %b want 1", in_ready); end
      tick;
      // x7 is still busy from the illegal-instruction test; clear and re-set it in one cycle.
      drive(1'b1, i_type(12'd1, 5'd1, 3'b000, 5'd7, OPC_OP_IMM), 1'b1, 5'd7, 32'd99);
      checks++; if (in_ready !== 1'b1)      begin errors++; $display("FAIL race_accept: got %b want 1", in_ready); end
      tick;
      checks++; if (rd !== 5'd7 || op1 !== 32'd5 || op2 !== 32'd1) begin errors++; $display("FAIL race_out: got rd=%0d op1=%h op2=%h want rd=7 op1=5 op2=1", rd, op1, op2); end
      drive(1'b1, r_type(F7_BASE, 5'd0, 5'd7, 3'b000, 5'd13, OPC_OP), 1'b0, 5'd0, 32'd0);
      checks++; if (in_ready !== 1'b0)      begin errors++; $display("FAIL race_busy_kept: got %b want 0", in_ready); end
      tick;
      drive(1'b1, r_type(F7_BASE, 5'd0, 5'd7, 3'b000, 5'd13, OPC_OP), 1'b1, 5'd7, 32'd6);
      tick;
      checks++; if (op1 !== 32'd6 || rd !== 5'd13) begin errors++; $display("FAIL race_bypass: got op1=%h rd=%0d want op1=6 rd=13", op1, rd); end
      drive(1'b0, 32'd0, 1'b0, 5'd0, 32'd0); tick;
   endtask

   task automatic test_reset_mid_stall;
      drive(1'b1, i_type(12'd1, 5'd0, 3'b000, 5'd5, OPC_OP_IMM), 1'b0, 5'd0, 32'd0); tick;
      drive(1'b1, r_type(F7_BASE, 5'd1, 5'd5, 3'b000, 5'd6, OPC_OP), 1'b0, 5'd0, 32'd0);
      checks++; if (in_ready !== 1'b0)      begin errors++; $display("FAIL mid_stall: got %b want 0", in_ready); end
      rst = 1'b1;
      tick;
      checks++; if (out_valid !== 1'b0)     begin errors++; $display("FAIL mid_rst_valid: got %b want 0", out_valid); end
      drive(1'b1, r_type(F7_BASE, 5'd1, 5'd5, 3'b000, 5'd6, OPC_OP), 1'b0, 5'd0, 32'd0);
      rst = 1'b0; #1;
      checks++; if (in_ready !== 1'b1)      begin errors++; $display("FAIL mid_rst_ready: got %b want 1", in_ready); end
      tick;
      checks++; if (out_valid !== 1'b1 || op2 !== 32'd0 || rd !== 5'd6)
         begin errors++; $display("FAIL mid_rst_out: got v=%b op2=%h rd=%0d want v=1 op2=0 rd=6", out_valid, op2, rd); end
      drive(1'b0, 32'd0, 1'b0, 5'd0, 32'd0); tick;
   endtask

   initial begin
      rst = 1'b1; in_valid = 1'b0; in_instr = '0; out_ready = 1'b1;
      wb_en = 1'b0; wb_rd = '0; wb_data = '0;
      test_reset;
      test_addi_add;
      test_shifts;
      test_illegal;
      test_backpressure;
      test_x0_race;
      test_reset_mid_stall;
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
